// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the hex-to-glyph helper used by the
// display blocks. Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Entry i is the glyph for nibble i; the concatenation lists F down to 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder shared by the display blocks.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seg_mux_driver.sv
// Four-digit multiplexed seven-segment driver with a per-slot anode guard.
// Define SEG_FRAME_LATCH_EN to snapshot the source data once per frame.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int PW = (DIV > 4) ? $clog2(DIV) : 2;

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [15:0]   dig_q;
  logic [3:0]    blk_q;
  logic [3:0]    dp_q;
  logic          slot_end;
  logic          frame_end;
  logic          in_guard;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_glyph;

  assign slot_end  = (pcnt == PW'(DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);
  assign in_guard  = (pcnt < PW'(GUARD));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pcnt <= '0;
      idx  <= 2'd0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

`ifdef SEG_FRAME_LATCH_EN
  // One snapshot per frame keeps all four digits consistent while scrolling.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dig_q <= 16'h0000;
      blk_q <= 4'hF;
      dp_q  <= 4'h0;
    end else if (frame_end) begin
      dig_q <= digits_in;
      blk_q <= blank_in;
      dp_q  <= dp_in;
    end
  end
`else
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dig_q <= 16'h0000;
      blk_q <= 4'hF;
      dp_q  <= 4'h0;
    end else begin
      dig_q <= digits_in;
      blk_q <= blank_in;
      dp_q  <= dp_in;
    end
  end
`endif

  always_comb begin
    cur_nibble = dig_q[3:0];
    case (idx)
      2'd0: cur_nibble = dig_q[3:0];
      2'd1: cur_nibble = dig_q[7:4];
      2'd2: cur_nibble = dig_q[11:8];
      2'd3: cur_nibble = dig_q[15:12];
      default: cur_nibble = dig_q[3:0];
    endcase
  end

  seg_hex_decode u_decode (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  // Blanked digits keep driving seg/dp; only the anode is suppressed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= (in_guard || blk_q[idx]) ? AN_OFF : ~(4'b0001 << idx);
      seg        <= cur_glyph;
      dp         <= ~dp_q[idx];
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Self-checking bench for seg_mux_driver with DIV=4, GUARD=1; the model
// derives every output from the edge count since reset release.
module tb_seg_mux_driver;

  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  blank_in  = 4'h0;
  logic [3:0]  dp_in     = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int ft_count = 0;
  int an_bad = 0;
  int dp_low = 0;
  int dp_wrong = 0;

  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_mux_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .clr        (clr),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Model: n is the number of edges since release; the outputs after edge
  // n+1 show digit (n/DIV)%4 at slot position n%DIV using the source data
  // captured so far.
  int          n = 0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_blk = 4'hF;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_ft = 1'b0;
  int          m_p;
  int          m_d;
  logic        m_load;

  assign m_p = n % DIV;
  assign m_d = (n / DIV) % 4;
`ifdef SEG_FRAME_LATCH_EN
  assign m_load = ((n % FRAME) == FRAME - 1);
`else
  assign m_load = 1'b1;
`endif

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      n     <= 0;
      m_dig <= 16'h0;
      m_blk <= 4'hF;
      m_dp  <= 4'h0;
      e_an  <= 4'hF;
      e_seg <= 7'h7F;
      e_dp  <= 1'b1;
      e_ft  <= 1'b0;
    end else begin
      n     <= n + 1;
      e_seg <= glyph_tab[m_dig[m_d*4 +: 4]];
      e_dp  <= ~m_dp[m_d];
      e_an  <= (m_p < GUARD || m_blk[m_d]) ? 4'hF : ~(4'b0001 << m_d);
      e_ft  <= (m_p == DIV - 1) && (m_d == 3);
      if (m_load) begin
        m_dig <= digits_in;
        m_blk <= blank_in;
        m_dp  <= dp_in;
      end
    end
  end

  task automatic compareModel();
    checks++;
    if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft}) begin
      errors++;
      $display("[TB] FAIL model edge=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
               n, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] x_an,
                             input logic [6:0] x_seg, input logic x_dp, input logic x_ft);
    checks++;
    if ({an, seg, dp, frame_tick} !== {x_an, x_seg, x_dp, x_ft}) begin
      errors++;
      $display("[TB] FAIL %s got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
               name, an, seg, dp, frame_tick, x_an, x_seg, x_dp, x_ft);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
  endtask

  // Advance k falling edges, checking the model and tallying observations.
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
      if (frame_tick) ft_count++;
      if (an == 4'b1011) an_bad++;
      if (!dp) begin
        dp_low++;
        if ((((n - 1) / DIV) % 4) != 0) dp_wrong++;
      end
      compareModel();
    end
  endtask

  task automatic resetDut(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    clr = 1'b1;
    applyStimulus(d, b, p);
    step(2);
    clr = 1'b0;
    ft_count = 0;
    an_bad   = 0;
    dp_low   = 0;
    dp_wrong = 0;
  endtask

  initial begin
    clr = 1'b1;
    $display("[TB] start DIV=%0d GUARD=%0d", DIV, GUARD);

    // Reset values, guard, first slots with 1234.
    resetDut(16'h1234, 4'h0, 4'h0);
    checkOutput("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(1);
    checkOutput("s0_guard", 4'hF, 7'h40, 1'b1, 1'b0);
    step(1);
`ifdef SEG_FRAME_LATCH_EN
    checkOutput("s0_body", 4'hF, 7'h40, 1'b1, 1'b0);
`else
    checkOutput("s0_body", 4'b1110, 7'h19, 1'b1, 1'b0);
`endif
    step(4);
`ifdef SEG_FRAME_LATCH_EN
    checkOutput("s1_body", 4'hF, 7'h40, 1'b1, 1'b0);
`else
    checkOutput("s1_body", 4'b1101, 7'h30, 1'b1, 1'b0);
`endif
    step(12);
    checkOutput("f2_s0", 4'b1110, 7'h19, 1'b1, 1'b0);
    step(4);
    checkOutput("f2_s1", 4'b1101, 7'h30, 1'b1, 1'b0);

    // Full frame of ABCD and frame_tick rate.
    resetDut(16'hABCD, 4'h0, 4'h0);
    step(18);
    checkOutput("abcd_d0", 4'b1110, 7'h21, 1'b1, 1'b0);
    step(4);
    checkOutput("abcd_d1", 4'b1101, 7'h46, 1'b1, 1'b0);
    step(4);
    checkOutput("abcd_d2", 4'b1011, 7'h03, 1'b1, 1'b0);
    step(4);
    checkOutput("abcd_d3", 4'b0111, 7'h08, 1'b1, 1'b0);
    step(2);
    checkOutput("abcd_tick", 4'b0111, 7'h08, 1'b1, 1'b1);
    checkCount("tick_count", ft_count, 2);

    // Blank digit 2, decimal point on digit 0.
    resetDut(16'h5678, 4'b0100, 4'b0001);
    step(FRAME);
    dp_low   = 0;
    dp_wrong = 0;
    step(10);
    checkOutput("blank_d2", 4'hF, 7'h02, 1'b1, 1'b0);
    step(6);
    checkCount("an_1011_seen", an_bad, 0);
    checkCount("dp_low_cycles", dp_low, DIV);
    checkCount("dp_low_wrong_slot", dp_wrong, 0);

    // Input change during slot 1 of the second frame.
    resetDut(16'h1111, 4'h0, 4'h0);
    step(21);
    applyStimulus(16'h2222, 4'h0, 4'h0);
    step(1);
    checkOutput("chg_e22", 4'b1101, 7'h79, 1'b1, 1'b0);
    step(1);
`ifdef SEG_FRAME_LATCH_EN
    checkOutput("chg_e23", 4'b1101, 7'h79, 1'b1, 1'b0);
`else
    checkOutput("chg_e23", 4'b1101, 7'h24, 1'b1, 1'b0);
`endif
    step(9);
`ifdef SEG_FRAME_LATCH_EN
    checkOutput("chg_e32", 4'b0111, 7'h79, 1'b1, 1'b1);
`else
    checkOutput("chg_e32", 4'b0111, 7'h24, 1'b1, 1'b1);
`endif
    step(2);
    checkOutput("chg_e34", 4'b1110, 7'h24, 1'b1, 1'b0);

    // Reset asserted at pcnt=2 of slot 2, then restart at digit 0.
    resetDut(16'h1234, 4'h0, 4'h0);
    step(10);
    clr = 1'b1;
    #1;
    checkOutput("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(1);
    clr = 1'b0;
    step(2);
`ifdef SEG_FRAME_LATCH_EN
    checkOutput("restart_d0", 4'hF, 7'h40, 1'b1, 1'b0);
`else
    checkOutput("restart_d0", 4'b1110, 7'h19, 1'b1, 1'b0);
`endif

    // Sweep every nibble through digit 0.
    resetDut(16'h0000, 4'h0, 4'h0);
    step(FRAME);
    for (int v = 0; v < 16; v++) begin
      logic [15:0] word;
      word = 16'(v);
      applyStimulus(word, 4'h0, 4'h0);
      step(FRAME + 2);
      checkOutput($sformatf("sweep_%0h", v), 4'b1110, glyph_tab[v], 1'b1, 1'b0);
      step(FRAME - 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_mux_driver.md
# seg_mux_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display. Consumes the 16-bit, four-hex-digit word produced by the scrolling-message stage and drives active-low anode enables, segment cathodes and decimal point. Scans one digit per slot, with a guard interval against ghosting. Sits directly downstream of the scroll stage, on the same board clock.

## Interface
- `DIV`, 50000: clock cycles per digit slot (1 ms at 50 MHz); legal range 4..2^20.
- `GUARD`, 2: cycles at the start of each slot during which all anodes are off; must be < `DIV`.
- `clk` input 1: board clock; all state on rising edge.
- `clr` input 1: reset, asynchronous, active-high.
- `digits_in` input 16: four hex nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3 (leftmost).
- `blank_in` input 4: per-digit blank; 1 forces that digit's anode off for its whole slot.
- `dp_in` input 4: per-digit decimal point; 1 lights the DP.
- `an` output 4: anode enables, active-low; `an[i]` is digit i.
- `seg` output 7: cathodes, active-low, `{g,f,e,d,c,b,a}`.
- `dp` output 1: decimal-point cathode, active-low.
- `frame_tick` output 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Prescaler `pcnt` counts 0..DIV-1 and wraps. `slot_end` is asserted when `pcnt == DIV-1`.
- Digit index `idx` (2 bits) increments on `slot_end`, mod 4, in order 0,1,2,3,0.
- Source registers (`dig_q`, `blk_q`, `dp_q`) hold the displayed data. Load rule depends on configuration.
- Glyph decode, active-low `{g..a}`:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- All outputs are registered. Each cycle they load from `idx` and `pcnt`:
  - `seg`: glyph of nibble `idx` of `dig_q`.
  - `dp`: `~dp_q[idx]`.
  - `an`: one-hot-low at bit `idx`, or 4'b1111 if `pcnt < GUARD` or `blk_q[idx]`.
- A blanked digit still drives `seg`/`dp`; only its anode is suppressed.
- `frame_tick` is registered. It is 1 in the cycle after the edge where `slot_end` occurs with `idx == 3`.

## Timing
- Reset values:
  - `pcnt`=0, `idx`=0, `dig_q`=0, `blk_q`=4'hF, `dp_q`=0.
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_tick`=0.
- Reset asserted mid-slot: all state returns to reset values immediately. No partial slot completes.
- After `clr` falls, the first edge starts slot 0 with `pcnt`=0.
  - `an` stays 4'b1111 for `GUARD` cycles (guard), then drives 4'b1110.
- Output latency: one cycle from `idx`/`pcnt`/source registers to pins.
- Slot length: exactly `DIV` cycles. Frame length: `4*DIV` cycles.
- Input changes take effect per the configuration load rule. There is no handshake; inputs are sampled level-wise.

## Configuration
- `SEG_FRAME_LATCH_EN` defined:
  - Source registers load only on the edge where `slot_end && idx == 3`. All four digits of a frame therefore come from one snapshot, so scroll updates never tear.
  - After reset, blanks persist (`blk_q`=F) until the first frame boundary, `4*DIV` cycles in.
- `SEG_FRAME_LATCH_EN` undefined:
  - Source registers load every cycle. The displayed digit reflects the inputs one cycle earlier.

## Structure
- Package `seg_pkg`: the 16-entry glyph constant table, `SEG_OFF` (7'h7F), `AN_OFF` (4'hF), and function `hex_to_seg`.
- Sub-module `seg_hex_decode`: combinational nibble-to-glyph decoder wrapping `hex_to_seg`. It is shared with other display blocks.
- Prescaler, scan index, source registers and output registers live in `seg_mux_driver`.

## Test plan
All scenarios use `DIV`=4 and `GUARD`=1.
- Reset hold, then release; `digits_in`=16'h1234, `blank_in`=0 (latch undefined) -> slot 0 cycle 1: `an`=1111. Cycles 2-4: `an`=1110, `seg`=7'h19 ("4"). Slot 1: `an`=1101, `seg`=7'h30.
- Full frame with `digits_in`=16'hABCD -> `seg` sequence 21, 46, 03, 08. `frame_tick` pulses exactly once per 16 cycles.
- `blank_in`=4'b0100, `dp_in`=4'b0001 -> `an` never 1011. `dp`=0 only during digit 0 slot.
- With `SEG_FRAME_LATCH_EN`: change `digits_in` from 16'h1111 to 16'h2222 during slot 1 -> remainder of frame shows "1". Next frame shows "2" on all digits.
- Assert `clr` at `pcnt`=2 of slot 2 -> same cycle `an`=1111, `seg`=7F. After release, scan restarts at digit 0.
- Sweep nibbles 0-F on digit 0 -> `seg` matches the glyph table entry for each.
